// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end with a 2-entry {pc, instr} queue.
// Keeps at most one instruction-memory request outstanding and reserves a
// queue slot for it at issue time. Redirects flush the queue and retarget
// fetch; an in-flight response belonging to the old path is dropped.
// Optional build macro: FETCH_BYPASS_EN -- when defined, a response arriving
// while the queue is empty is presented to decode in the same cycle.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [4:0]  if_opcode
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] fetch_pc_reg, fetch_pc_next;
    logic [1:0]  count_reg, count_next;
    logic        rd_ptr_reg, wr_ptr_reg;

    logic        fifo_empty;
    logic        ack_live;
    logic        bypass;
    logic        out_valid;
    logic        handshake;
    logic        fifo_pop;
    logic        fifo_push;
    logic        req_comb;
    logic [1:0]  occ_after_pop;
    logic [31:0] head_pc, head_instr;
    logic [31:0] out_pc, out_instr;
    logic        redirect_align_unused;

    // Low address bits of a redirect target are discarded (word alignment).
    assign redirect_align_unused = ^redirect_pc[1:0];

    assign fifo_empty = (count_reg == 2'd0);
    // A response only counts when it answers a live request.
    assign ack_live   = imem_ack && (state_reg == WAIT);

`ifdef FETCH_BYPASS_EN
    assign bypass = ack_live && fifo_empty && !redirect_valid;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = !fifo_empty || bypass;
    assign handshake = out_valid && !stall;
    assign fifo_pop  = handshake && !fifo_empty;
    // A bypassed word that decode takes immediately never enters the queue.
    assign fifo_push = ack_live && !redirect_valid && !(bypass && !stall);

    assign occ_after_pop = count_reg - {1'b0, fifo_pop};
    assign count_next    = count_reg + {1'b0, fifo_push} - {1'b0, fifo_pop};

    // Queue storage: one register pair per slot, written at the write pointer.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [31:0] pc_reg;
            logic [31:0] instr_reg;
            logic        wr_sel;

            assign wr_sel = fifo_push && (wr_ptr_reg == 1'(gi));

            // Capture the returning word and its address into this slot.
            always_ff @(posedge clk) begin
                if (rst) begin
                    pc_reg    <= '0;
                    instr_reg <= '0;
                end else if (wr_sel) begin
                    pc_reg    <= fetch_pc_reg;
                    instr_reg <= imem_rdata;
                end
            end
        end
    endgenerate

    assign head_pc    = rd_ptr_reg ? g_entry[1].pc_reg    : g_entry[0].pc_reg;
    assign head_instr = rd_ptr_reg ? g_entry[1].instr_reg : g_entry[0].instr_reg;

    // Queue pointers and occupancy; a redirect empties the queue outright.
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            count_reg  <= 2'd0;
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (fifo_push) wr_ptr_reg <= ~wr_ptr_reg;
            if (fifo_pop)  rd_ptr_reg <= ~rd_ptr_reg;
        end
    end

    // Fetch state and fetch address registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= RESET_PC;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
        end
    end

    // Request issue, response tracking and fetch address sequencing.
    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        req_comb      = 1'b0;
        case (state_reg)
            IDLE: begin
                // Issue only if a slot remains once this cycle's pop is counted.
                if (!redirect_valid && (occ_after_pop <= 2'd1)) begin
                    req_comb   = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                req_comb = 1'b1;
                if (imem_ack) begin
                    if (redirect_valid) begin
                        state_next = IDLE;
                    end else begin
                        fetch_pc_next = fetch_pc_reg + 32'd4;
                        // Chain the next request when a slot is left for it.
                        state_next = (count_next <= 2'd1) ? WAIT : IDLE;
                    end
                end else if (redirect_valid) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                // The stale response is swallowed here; a redirect arriving
                // with it only retargets fetch, since nothing else is in flight.
                if (imem_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (redirect_valid) fetch_pc_next = {redirect_pc[31:2], 2'b00};
    end

    assign out_pc    = bypass ? fetch_pc_reg : head_pc;
    assign out_instr = bypass ? imem_rdata   : head_instr;

    assign imem_req  = !rst && req_comb;
    assign imem_addr = fetch_pc_reg;
    assign if_valid  = !rst && out_valid;
    assign if_pc     = rst ? 32'd0 : out_pc;
    assign if_instr  = rst ? 32'd0 : out_instr;
    assign if_opcode = if_instr[6:2];

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 Port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst  in  1  reset; synchronous, active-high.
REQ-004 Port: imem_req  out  1  instruction-memory request valid.
REQ-005 Port: imem_addr  out  32  word-aligned fetch address.
REQ-006 Port: imem_ack  in  1  response strobe; imem_rdata is valid in the same cycle.
REQ-007 Port: imem_rdata  in  32  fetched instruction word.
REQ-008 Port: redirect_valid  in  1  branch/jump target strobe from execute.
REQ-009 Port: redirect_pc  in  32  new fetch target.
REQ-010 Port: stall  in  1  decode not accepting this cycle.
REQ-011 Port: if_valid  out  1  if_instr/if_pc/if_opcode hold a valid instruction.
REQ-012 Port: if_instr  out  32  instruction word to decode.
REQ-013 Port: if_pc  out  32  address of if_instr.
REQ-014 Port: if_opcode  out  5  if_instr[6:2]; the opcode field consumed by the control unit.

Function
REQ-015 The block SHALL hold a 2-entry FIFO of {pc, instr}; outputs SHALL show the head entry; if_valid = FIFO not empty.
REQ-016 A handshake SHALL occur when if_valid && !stall; the head is popped on that edge.
REQ-017 The FSM SHALL have states IDLE, WAIT, DROP; at most one request outstanding.
REQ-018 IDLE -> WAIT: imem_req asserted with imem_addr = fetch_pc when free slots (2 - occupancy + pop this cycle) >= 1 and !redirect_valid.
REQ-019 In WAIT, imem_req and imem_addr SHALL stay constant until imem_ack; ack may arrive 1..N cycles after the request.
REQ-020 On ack in WAIT: push {imem_addr, imem_rdata}; fetch_pc += 4 (mod 2^32, wrap from 32'hFFFF_FFFC to 0); next state IDLE, or WAIT with the next request if a slot is free.
REQ-021 redirect_valid SHALL flush the FIFO (if_valid=0 next cycle) and load fetch_pc = {redirect_pc[31:2], 2'b00}, in any state.
REQ-022 Redirect in WAIT without ack in the same cycle -> DROP; in DROP imem_req=0, the next ack is discarded, then -> IDLE.
REQ-023 Redirect in the same cycle as ack: the acked word SHALL be discarded, not pushed; next state IDLE.
REQ-024 Redirect takes priority over push and pop in the same cycle; a pop in that cycle is still a valid handshake.
REQ-025 Full FIFO and stall: no new request; outputs stable; no entry is lost or duplicated.
REQ-026 Push and pop in the same cycle with occupancy 2 SHALL be legal only if the request was issued under REQ-018 (slot reserved); occupancy is never exceeded.
REQ-027 Redirect in DROP SHALL update fetch_pc and remain in DROP.
REQ-028 Latency without bypass: ack at edge N -> if_valid at cycle N+1.

Reset
REQ-029 While rst=1: fetch_pc=RESET_PC, FIFO empty, state IDLE, imem_req=0, if_valid=0, if_instr=0, if_pc=0, if_opcode=0; rst dominates redirect and ack.
REQ-030 Reset during WAIT SHALL abandon the request; the first ack after reset released with no new request issued SHALL be ignored.
REQ-031 First request SHALL be issued in the first cycle after rst deasserts, addr=RESET_PC.

Configuration
REQ-032 Macro FETCH_BYPASS_EN: when defined, if the FIFO is empty, ack arrives and there is no redirect, imem_rdata/imem_addr SHALL appear on the outputs combinationally with if_valid=1 that cycle; if !stall the word is consumed and not pushed, else it is pushed.
REQ-033 Without FETCH_BYPASS_EN, outputs come only from FIFO registers (REQ-028); all other behaviour is identical.

Verification
REQ-034 Reset, RESET_PC=0, ack 1 cycle after each req, stall=0 -> imem_addr 0,4,8,...; if_pc follows in order; if_opcode=if_instr[6:2].
REQ-035 stall=1 for 5 cycles -> FIFO fills to 2 (pc 0,4), imem_req drops, no request for pc 8 until a pop; release -> pc 0,4,8 delivered once each.
REQ-036 Redirect to 32'h0000_0103 while WAIT on pc 8 (ack 2 cycles later) -> DROP, late ack discarded, next req addr 32'h0000_0100, if_valid=0 meanwhile.
REQ-037 Redirect to 32'h40 in same cycle as ack for pc 12 -> word for 12 never appears; next if_pc=32'h40.
REQ-038 Redirect to 32'hFFFF_FFFC -> fetches FFFF_FFFC then 0000_0000 (wrap).
REQ-039 With FETCH_BYPASS_EN, empty FIFO, ack with rdata 32'h0000_0033 -> if_valid=1, if_opcode=5'b01100 same cycle; without the macro, one cycle later.
